// File: rtl/bpm2per_pkg.sv
// Shared TapTempo timing constants and types for the BPM <-> period converters.
// Defaults: 40 ns clock, 5120 clocks per tick, BPM clamp 250.
package bpm2per_pkg;

    localparam int unsigned     DEF_CLK_PER_NS = 40;
    localparam int unsigned     DEF_TP_CYCLE   = 5120;
    localparam int unsigned     DEF_BPM_MAX    = 250;
    localparam longint unsigned NS_PER_MIN     = 64'd60_000_000_000;

    // Ticks per minute, i.e. the numerator of both period<->BPM conversions.
    function automatic int unsigned calc_dividend(input int unsigned clk_ns,
                                                  input int unsigned tp_cyc);
        longint unsigned q;
        q = NS_PER_MIN / (64'(clk_ns) * 64'(tp_cyc));
        return 32'(q);
    endfunction

    localparam longint unsigned MIN_NS       = NS_PER_MIN / DEF_BPM_MAX;
    localparam int unsigned     DEF_DIVIDEND = calc_dividend(DEF_CLK_PER_NS, DEF_TP_CYCLE);
    localparam int unsigned     DEF_PER_W    = $clog2(DEF_DIVIDEND + 1);
    localparam int unsigned     DEF_BPM_W    = $clog2(DEF_BPM_MAX + 1);
    localparam int unsigned     BTN_PER_MIN  = DEF_DIVIDEND / DEF_BPM_MAX;
    localparam int unsigned     BTN_PER_MAX  = DEF_DIVIDEND;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bpm2per_if.sv
// BPM request / period result / beat bundle between the tempo register path and the beat output.
// No flow control: requests are dropped while busy_o is high.
interface bpm2per_if import bpm2per_pkg::*; #(
    parameter int unsigned PER_W = DEF_PER_W,
    parameter int unsigned BPM_W = DEF_BPM_W
);
    logic             tp_i;
    logic [BPM_W-1:0] bpm_i;
    logic             bpm_valid_i;
    logic             busy_o;
    logic [PER_W-1:0] per_o;
    logic             per_valid_o;
    logic             beat_o;

    modport master (output tp_i, bpm_i, bpm_valid_i,
                    input  busy_o, per_o, per_valid_o, beat_o);
    modport slave  (input  tp_i, bpm_i, bpm_valid_i,
                    output busy_o, per_o, per_valid_o, beat_o);
endinterface

// File: rtl/bpm2per_seqdiv.sv
// tt_seqdiv: restoring divider, one quotient bit per cycle MSB first; done_o pulses QW cycles
// after start_i. start_i restarts any division in progress; no backpressure.
module tt_seqdiv #(
    parameter int unsigned QW = 19,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [QW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          done_o,
    output logic [QW-1:0] quot_o
);
    localparam int unsigned RW = QW + DW;
    localparam int unsigned CW = $clog2(QW + 1);

    logic [RW-1:0] rem_q, den_q, diff;
    logic [QW-1:0] quot_q;
    logic [CW-1:0] cnt_q;
    logic          done_q, ge;

    always_comb begin
        ge   = (rem_q >= den_q);
        diff = rem_q - den_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // divisor starts at weight 2^(QW-1) so QW steps cover every quotient bit
                rem_q  <= RW'(dividend_i);
                den_q  <= RW'({divisor_i, {(QW-1){1'b0}}});
                quot_q <= '0;
                cnt_q  <= CW'(QW);
            end else if (cnt_q != '0) begin
                if (ge) rem_q <= diff;
                quot_q <= {quot_q[QW-2:0], ge};
                den_q  <= den_q >> 1;
                cnt_q  <= cnt_q - CW'(1);
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;
endmodule

// File: rtl/bpm2per.sv
// BPM -> beat period (ticks) via sequential divide, plus a free-running metronome on tp_i.
// Result 20 cycles after accept; requests while busy_o are dropped.
module bpm2per import bpm2per_pkg::*; #(
    parameter int unsigned CLK_PER_NS = DEF_CLK_PER_NS,
    parameter int unsigned TP_CYCLE   = DEF_TP_CYCLE,
    parameter int unsigned BPM_MAX    = DEF_BPM_MAX
) (
    input  logic      clk_i,
    input  logic      rst_i,
    bpm2per_if.slave  bus
);
    localparam int unsigned DIVIDEND = calc_dividend(CLK_PER_NS, TP_CYCLE);
    localparam int unsigned PER_W    = $clog2(DIVIDEND + 1);
    localparam int unsigned BPM_W    = $clog2(BPM_MAX + 1);

    state_e           state_q, state_d;
    logic             busy, div_start, div_done;
    logic [BPM_W-1:0] bpm_cl;
    logic [PER_W-1:0] div_quot, per_q;
    logic             per_vld_q;
    logic [PER_W-1:0] active_q, pend_q, cnt_q;
    logic             pend_vld_q, beat_q;

    always_comb begin
        bpm_cl = bus.bpm_i;
        if (bus.bpm_i == '0)                     bpm_cl = BPM_W'(1);
        else if (bus.bpm_i > BPM_W'(BPM_MAX))    bpm_cl = BPM_W'(BPM_MAX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.bpm_valid_i) state_d = ST_DIV;
            ST_DIV:  if (div_done)        state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE:         div_start = bus.bpm_valid_i;
            ST_DIV, ST_DONE: busy      = 1'b1;
            default:         busy      = 1'b0;
        endcase
    end

    tt_seqdiv #(.QW(PER_W), .DW(BPM_W)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .dividend_i (PER_W'(DIVIDEND)),
        .divisor_i  (bpm_cl),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_q     <= '0;
            per_vld_q <= 1'b0;
        end else begin
            per_vld_q <= (state_q == ST_DIV) && div_done;
            if ((state_q == ST_DIV) && div_done) per_q <= div_quot;
        end
    end

    // A new period takes over only at a beat boundary, so the running interval is never cut short.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            beat_q     <= 1'b0;
        end else begin
            beat_q <= 1'b0;
            if (per_vld_q && (active_q == '0)) begin
                active_q <= per_q;
                cnt_q    <= '0;
            end else begin
                if (bus.tp_i && (active_q != '0)) begin
                    if (cnt_q == active_q - PER_W'(1)) begin
                        beat_q <= 1'b1;
                        cnt_q  <= '0;
                        if (pend_vld_q) begin
                            active_q   <= pend_q;
                            pend_vld_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + PER_W'(1);
                    end
                end
                if (per_vld_q) begin
                    pend_q     <= per_q;
                    pend_vld_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy_o      = busy;
    assign bus.per_o       = per_q;
    assign bus.per_valid_o = per_vld_q;
    assign bus.beat_o      = beat_q;
endmodule
